// File: rtl/dsp_pkg.sv
// Shared types and width helpers for the dot-product engine and the layer accumulator.
package dsp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        REDUCE,
        OUT
    } dp_state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Full-precision accumulator width: N products of two W-bit operands plus a sign guard.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/dp_round_sat.sv
// Combinational round-half-up and saturate from IN_W fixed-point down to W bits.
// Zero latency; no handshake, output follows sum_i.
module dp_round_sat #(
    parameter int IN_W = 36,
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic signed [IN_W-1:0] sum_i,
    output logic        [W-1:0]    out_o,
    output logic                   sat_o
);

    // One spare bit so adding the rounding constant can never wrap.
    localparam int RW = IN_W + 1;
    localparam logic signed [RW-1:0] HALF = RW'(64'd1 << (FRAC - 1));
    localparam logic signed [RW-1:0] MAXV = RW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    logic signed [RW-1:0] biased_d;
    logic signed [RW-1:0] r_d;

    always_comb begin
        biased_d = $signed({sum_i[IN_W-1], sum_i}) + HALF;
        r_d      = biased_d >>> FRAC;
        out_o    = r_d[W-1:0];
        sat_o    = 1'b0;
        if (r_d > MAXV) begin
            out_o = MAXV[W-1:0];
            sat_o = 1'b1;
        end else if (r_d < MINV) begin
            out_o = MINV[W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/dot_product_seq.sv
// LANES-wide pipelined MAC dot product of two N-element fixed-point vectors, rounded and saturated.
// valid_o K+3 cycles after accept (K = ceil(N/LANES)); start_i ignored while busy_o, never queued.
module dot_product_seq
    import dsp_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int LANES = 2,
    parameter int FRAC  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [N*W-1:0]   a_i,
    input  logic [N*W-1:0]   b_i,
    output logic             busy_o,
    output logic [W-1:0]     out_o,
    output logic             valid_o,
    output logic             sat_o
);

    localparam int K      = ceil_div(N, LANES);
    localparam int KW     = $clog2(K) + 1;
    localparam int ACC_W  = acc_width(W, N);
    localparam int PROD_W = 2 * W;
    localparam int PAD_W  = K * LANES * W;

    dp_state_t                 state_q;
    logic [KW-1:0]             k_q;
    logic [PAD_W-1:0]          a_q;
    logic [PAD_W-1:0]          b_q;
    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic signed [ACC_W-1:0]   acc_q  [LANES];
    logic signed [ACC_W-1:0]   sum_q;
    logic [W-1:0]              out_q;
    logic                      sat_q;
    logic                      valid_q;
    logic                      busy_q;

    logic [PAD_W-1:0]          a_pad;
    logic [PAD_W-1:0]          b_pad;
    logic signed [PROD_W-1:0]  prod_d [LANES];
    logic signed [ACC_W-1:0]   sum_d;
    logic [W-1:0]              rs_out;
    logic                      rs_sat;

    // Zero-extending the operand vectors to K*LANES elements gives the zero pad for indices >= N.
    assign a_pad = PAD_W'(a_i);
    assign b_pad = PAD_W'(b_i);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_d[l] = '0;
            for (int g = 0; g < K; g++) begin
                if (k_q == KW'(g)) begin
                    prod_d[l] = $signed(a_q[(g*LANES+l)*W +: W]) * $signed(b_q[(g*LANES+l)*W +: W]);
                end
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_d = sum_d + acc_q[l];
        end
    end

    dp_round_sat #(
        .IN_W (ACC_W),
        .W    (W),
        .FRAC (FRAC)
    ) u_round_sat (
        .sum_i (sum_q),
        .out_o (rs_out),
        .sat_o (rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
                acc_q[l]  <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy_q is still high in the cycle valid_o pulses, which blocks a back-to-back accept.
                    busy_q <= 1'b0;
                    if (start_i && !busy_q) begin
                        a_q    <= a_pad;
                        b_q    <= b_pad;
                        k_q    <= '0;
                        busy_q <= 1'b1;
                        for (int l = 0; l < LANES; l++) begin
                            prod_q[l] <= '0;
                            acc_q[l]  <= '0;
                        end
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++) begin
                        prod_q[l] <= prod_d[l];
                        acc_q[l]  <= acc_q[l] + ACC_W'(prod_q[l]);
                    end
                    if (k_q == KW'(K - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_q[l] <= acc_q[l] + ACC_W'(prod_q[l]);
                    end
                    state_q <= REDUCE;
                end
                REDUCE: begin
                    sum_q   <= sum_d;
                    state_q <= OUT;
                end
                OUT: begin
                    out_q   <= rs_out;
                    sat_q   <= rs_sat;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed bench for dot_product_seq: one N=8/LANES=2 instance and one N=5/LANES=2 instance.
module tb_dot_product_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start8 = 1'b0;
    logic [127:0] a8 = '0;
    logic [127:0] b8 = '0;
    logic         busy8, valid8, sat8;
    logic [15:0]  out8;

    logic         start5 = 1'b0;
    logic [79:0]  a5 = '0;
    logic [79:0]  b5 = '0;
    logic         busy5, valid5, sat5;
    logic [15:0]  out5;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [15:0] av [8];
    logic signed [15:0] bv [8];

    always #5 clk = ~clk;

    dot_product_seq #(.W(16), .N(8), .LANES(2), .FRAC(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .busy_o  (busy8),
        .out_o   (out8),
        .valid_o (valid8),
        .sat_o   (sat8)
    );

    dot_product_seq #(.W(16), .N(5), .LANES(2), .FRAC(12)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start5),
        .a_i     (a5),
        .b_i     (b5),
        .busy_o  (busy5),
        .out_o   (out5),
        .valid_o (valid5),
        .sat_o   (sat5)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int g_out(input bit s);
        return s ? int'($signed(out5)) : int'($signed(out8));
    endfunction

    function automatic int g_valid(input bit s);
        return s ? int'(valid5) : int'(valid8);
    endfunction

    function automatic int g_busy(input bit s);
        return s ? int'(busy5) : int'(busy8);
    endfunction

    function automatic int g_sat(input bit s);
        return s ? int'(sat5) : int'(sat8);
    endfunction

    task automatic clr_vec;
        for (int i = 0; i < 8; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
    endtask

    task automatic load(input bit s);
        for (int i = 0; i < 8; i++) begin
            a8[i*16 +: 16] = av[i];
            b8[i*16 +: 16] = bv[i];
        end
        for (int i = 0; i < 5; i++) begin
            a5[i*16 +: 16] = av[i];
            b5[i*16 +: 16] = bv[i];
        end
        if (s) start5 = 1'b1;
        else   start8 = 1'b1;
    endtask

    // One transaction: accept, wait for valid_o, check latency/result, then check the drop of busy_o.
    task automatic run(input bit s, input int exp_out, input int exp_sat, input int exp_lat, input string tag);
        int cyc;
        bit seen;
        load(s);
        tick;
        start8 = 1'b0;
        start5 = 1'b0;
        chk({tag, "_busy_after_accept"}, g_busy(s), 1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick;
            cyc++;
            if (g_valid(s) == 1) seen = 1'b1;
        end
        chk({tag, "_latency"}, seen ? cyc : -1, exp_lat);
        chk({tag, "_out"}, g_out(s), exp_out);
        chk({tag, "_sat"}, g_sat(s), exp_sat);
        chk({tag, "_busy_at_valid"}, g_busy(s), 1);
        tick;
        chk({tag, "_valid_pulse"}, g_valid(s), 0);
        chk({tag, "_busy_drop"}, g_busy(s), 0);
        chk({tag, "_out_hold"}, g_out(s), exp_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nvalid;
        int lat;
        int first_out;

        clr_vec();
        tick;
        tick;
        chk("rst_busy", int'(busy8), 0);
        chk("rst_valid", int'(valid8), 0);
        chk("rst_sat", int'(sat8), 0);
        chk("rst_out", int'(out8), 0);
        chk("rst5_out", int'(out5), 0);
        rst = 1'b0;
        tick;

        // 1.0 * 0.5 = 0.5
        clr_vec();
        av[0] = 16'sd4096; bv[0] = 16'sd2048;
        run(0, 2048, 0, 7, "basic");

        // Rounding at the half-LSB boundary, both signs.
        clr_vec(); av[0] = 16'sd1;  bv[0] = 16'sd2048; run(0, 1, 0, 7, "rnd_half_pos");
        clr_vec(); av[0] = 16'sd1;  bv[0] = 16'sd2047; run(0, 0, 0, 7, "rnd_below_half");
        clr_vec(); av[0] = -16'sd1; bv[0] = 16'sd2048; run(0, 0, 0, 7, "rnd_half_neg");
        clr_vec(); av[0] = -16'sd1; bv[0] = 16'sd2049; run(0, -1, 0, 7, "rnd_neg_one");

        // All elements, both lanes: sum (i+1)*0.5 * (+/-0.125) = -0.25 -> -1024.
        for (int i = 0; i < 8; i++) begin
            av[i] = 16'((i + 1) * 2048);
            bv[i] = (i % 2 == 1) ? -16'sd512 : 16'sd512;
        end
        run(0, -1024, 0, 7, "mixed");

        // Saturation in both directions.
        for (int i = 0; i < 8; i++) begin av[i] = 16'sd4096; bv[i] = 16'sd4096; end
        run(0, 32767, 1, 7, "sat_pos");
        for (int i = 0; i < 8; i++) begin av[i] = -16'sd32768; bv[i] = 16'sd32767; end
        run(0, -32768, 1, 7, "sat_neg");

        // Starts while busy (including the valid_o cycle) and operand changes are ignored.
        clr_vec();
        av[0] = 16'sd4096; bv[0] = 16'sd2048;
        load(0);
        tick;
        start8    = 1'b0;
        nvalid    = 0;
        lat       = -1;
        first_out = 0;
        for (int c = 1; c <= 20; c++) begin
            tick;
            start8 = 1'b0;
            if (valid8) begin
                nvalid++;
                if (lat < 0) begin
                    lat       = c;
                    first_out = int'($signed(out8));
                end
            end
            if (c == 1 || c == 7) begin
                for (int i = 0; i < 8; i++) begin av[i] = 16'sd4096; bv[i] = 16'sd4096; end
                load(0);
            end
        end
        chk("busy_start_latency", lat, 7);
        chk("busy_start_out", first_out, 2048);
        chk("busy_start_valid_count", nvalid, 1);
        chk("busy_start_idle", int'(busy8), 0);

        clr_vec();
        av[0] = 16'sd2048; bv[0] = 16'sd2048;
        run(0, 1024, 0, 7, "after_busy");

        // Reset in the middle of an operation aborts it.
        for (int i = 0; i < 8; i++) begin av[i] = 16'sd4096; bv[i] = 16'sd1024; end
        load(0);
        tick;
        start8 = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy8), 0);
        chk("abort_out", int'(out8), 0);
        tick;
        rst    = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 15; c++) begin
            tick;
            if (valid8) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);
        chk("abort_idle_busy", int'(busy8), 0);
        chk("abort_idle_out", int'(out8), 0);
        run(0, 8192, 0, 7, "post_abort");

        // N=5 instance: K=3, zero-padded last group.
        clr_vec();
        for (int i = 0; i < 5; i++) begin av[i] = 16'((i + 1) * 4096); bv[i] = 16'sd4096; end
        run(1, 32767, 1, 6, "n5_sat");
        for (int i = 0; i < 5; i++) bv[i] = 16'sd256;
        run(1, 3840, 0, 6, "n5_frac");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
